// File: rtl/fadd_share_arb.sv
// Round-robin front end that lets NUM_REQ requesters share one fixed-latency fadd pipeline.
// Results are steered back through a credit-protected FIFO, tagged with the issuing requester.
module fadd_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int EXPWIDTH   = 8,
    parameter int PRECISION  = 24,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ*(EXPWIDTH+PRECISION)-1:0] req_a_i,
    input  logic [NUM_REQ*(EXPWIDTH+PRECISION)-1:0] req_b_i,
    input  logic [NUM_REQ*3-1:0]              req_rm_i,
    output logic                              fu_valid_o,
    output logic [EXPWIDTH+PRECISION-1:0]     fu_a_o,
    output logic [EXPWIDTH+PRECISION-1:0]     fu_b_o,
    output logic [2:0]                        fu_rm_o,
    input  logic                              fu_valid_i,
    input  logic [EXPWIDTH+PRECISION-1:0]     fu_result_i,
    input  logic [4:0]                        fu_fflags_i,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    input  logic [NUM_REQ-1:0]                rsp_ready_i,
    output logic [EXPWIDTH+PRECISION-1:0]     rsp_result_o,
    output logic [4:0]                        rsp_fflags_o
);
    localparam int W   = EXPWIDTH + PRECISION;
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  credit_cnt_q, credit_cnt_d;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;

    logic [LATENCY-1:0] tag_vld_q;
    logic [IDW-1:0]     tag_id_q [LATENCY];

    logic [IDW-1:0] fifo_id_q  [FIFO_DEPTH];
    logic [W-1:0]   fifo_res_q [FIFO_DEPTH];
    logic [4:0]     fifo_flg_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q;

    logic           push, pop, stray;
    logic [IDW-1:0] head_id;

    // Arbitration is gated by reset so nothing is offered while the unit is held in reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (rst_n && credit_cnt_q != '0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid_i[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
                end
            end
        end
    end

    assign req_ready_o = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    assign fu_valid_o  = gnt_any;
    assign fu_a_o      = req_a_i[int'(gnt_id) * W +: W];
    assign fu_b_o      = req_b_i[int'(gnt_id) * W +: W];
    assign fu_rm_o     = req_rm_i[int'(gnt_id) * 3 +: 3];

    assign push    = fu_valid_i && tag_vld_q[LATENCY-1];
    assign stray   = fu_valid_i && !tag_vld_q[LATENCY-1];
    assign head_id = fifo_id_q[rd_ptr_q];
    assign pop     = (cnt_q != '0) && rsp_ready_i[head_id];

    assign rsp_valid_o  = (cnt_q != '0) ? (NUM_REQ'(1) << head_id) : '0;
    assign rsp_result_o = fifo_res_q[rd_ptr_q];
    assign rsp_fflags_o = fifo_flg_q[rd_ptr_q];

    always_comb begin
        rr_ptr_d     = gnt_any ? rr_next(gnt_id) : rr_ptr_q;
        credit_cnt_d = credit_cnt_q;
        cnt_d        = cnt_q;
        case ({gnt_any, pop})
            2'b10:   credit_cnt_d = credit_cnt_q - 1'b1;
            2'b01:   credit_cnt_d = credit_cnt_q + 1'b1;
            default: credit_cnt_d = credit_cnt_q;
        endcase
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            credit_cnt_q <= CW'(FIFO_DEPTH);
            tag_vld_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            credit_cnt_q <= credit_cnt_d;
            tag_vld_q[0] <= gnt_any;
            for (int i = 1; i < LATENCY; i++) tag_vld_q[i] <= tag_vld_q[i-1];
            if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            cnt_q        <= cnt_d;
            if (stray) err_q <= 1'b1;
        end
    end

    // Payload storage carries no reset; validity lives in the control registers above.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_id;
        for (int i = 1; i < LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
        if (push) begin
            fifo_id_q[wr_ptr_q]  <= tag_id_q[LATENCY-1];
            fifo_res_q[wr_ptr_q] <= fu_result_i;
            fifo_flg_q[wr_ptr_q] <= fu_fflags_i;
        end
    end
endmodule

// File: tb/tb_fadd_share_arb.sv
// Directed bench for fadd_share_arb with a fixed-latency fadd stub and a response scoreboard.
module tb_fadd_share_arb;
    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 3;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [N*W-1:0] req_a_i, req_b_i;
    logic [N*3-1:0] req_rm_i;
    logic           fu_valid_o, fu_valid_i;
    logic [W-1:0]   fu_a_o, fu_b_o, fu_result_i, rsp_result_o;
    logic [2:0]     fu_rm_o;
    logic [4:0]     fu_fflags_i, rsp_fflags_o;

    int total, bad, npop;

    typedef struct packed {
        logic [N-1:0] oh;
        logic [W-1:0] res;
        logic [4:0]   fl;
    } exp_t;
    exp_t q[$];

    fadd_share_arb #(.NUM_REQ(N), .EXPWIDTH(8), .PRECISION(24), .LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rm_i(req_rm_i),
        .fu_valid_o(fu_valid_o), .fu_a_o(fu_a_o), .fu_b_o(fu_b_o), .fu_rm_o(fu_rm_o),
        .fu_valid_i(fu_valid_i), .fu_result_i(fu_result_i), .fu_fflags_i(fu_fflags_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_fflags_o(rsp_fflags_o)
    );

    always #5 clk = ~clk;

    // Stand-in for the fadd unit: one known IEEE sum, otherwise a cheap deterministic mix.
    function automatic logic [W-1:0] fmodel(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    function automatic logic [4:0] fflags(input logic [2:0] rm);
        return {2'b01, rm};
    endfunction

    logic [L-1:0] sv = '0;
    logic [W-1:0] sr [L];
    logic [4:0]   sf [L];
    always @(posedge clk) begin
        sv    <= {sv[L-2:0], fu_valid_o};
        sr[0] <= fmodel(fu_a_o, fu_b_o);
        sf[0] <= fflags(fu_rm_o);
        for (int i = 1; i < L; i++) begin
            sr[i] <= sr[i-1];
            sf[i] <= sf[i-1];
        end
    end
    assign fu_valid_i  = sv[L-1];
    assign fu_result_i = sr[L-1];
    assign fu_fflags_i = sf[L-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] rm);
        req_a_i[k*W +: W] = a;
        req_b_i[k*W +: W] = b;
        req_rm_i[k*3 +: 3] = rm;
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && q.size() != 0; c++) tick();
        check("drain_empty", q.size(), 0);
        tick();
        tick();
        check("drain_credit", dut.credit_cnt_q, D);
    endtask

    // Scoreboard: expectations enter at the issue handshake, leave at the response handshake.
    int   mid;
    exp_t e;
    always @(negedge clk) begin
        if (fu_valid_o) begin
            mid = -1;
            for (int k = N - 1; k >= 0; k--) if (req_ready_o[k]) mid = k;
            check("ready_onehot", 64'($onehot(req_ready_o)), 1);
            if (mid >= 0)
                q.push_back({N'(1) << mid, fmodel(req_a_i[mid*W +: W], req_b_i[mid*W +: W]),
                             fflags(req_rm_i[mid*3 +: 3])});
        end
        if ((rsp_valid_o & rsp_ready_i) != '0) begin
            npop++;
            if (q.size() == 0) check("rsp_unexpected", rsp_valid_o, 0);
            else begin
                e = q.pop_front();
                check("rsp_beat", {rsp_valid_o, rsp_result_o, rsp_fflags_o}, e);
            end
        end
        if (rst_n) check("credit_bound", 64'(dut.credit_cnt_q > D), 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int n, gid, p0;
    initial begin
        total = 0; bad = 0; npop = 0;
        rst_n = 1'b0;
        req_valid_i = '0; req_a_i = '0; req_b_i = '0; req_rm_i = '0; rsp_ready_i = '0;
        tick();
        req_valid_i = 4'hF;
        #1;
        check("rst_req_ready", req_ready_o, 0);
        check("rst_fu_valid", fu_valid_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_credit", dut.credit_cnt_q, D);
        check("rst_err", dut.err_q, 0);
        tick();
        req_valid_i = '0;
        rst_n = 1'b1;
        tick();

        // Single request from requester 1, result must not be bypassed
        set_req(1, 32'h3F80_0000, 32'h4000_0000, 3'd0);
        req_valid_i = 4'b0010;
        #1;
        check("single_ready", req_ready_o, 4'b0010);
        check("single_fu_valid", fu_valid_o, 1);
        check("single_fu_a", fu_a_o, 32'h3F80_0000);
        check("single_fu_b", fu_b_o, 32'h4000_0000);
        tick();
        req_valid_i = '0;
        tick();
        tick();
        check("single_no_bypass", rsp_valid_o, 0);
        tick();
        check("single_rsp_valid", rsp_valid_o, 4'b0010);
        check("single_rsp_result", rsp_result_o, 32'h4040_0000);
        rsp_ready_i = 4'hF;
        tick();
        check("single_after_pop", rsp_valid_o, 0);
        check("single_pops", npop, 1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Fairness with everyone requesting
        for (int k = 0; k < N; k++) set_req(k, 32'h0100_0000 * (k + 1), 32'h10 + k, 3'(k));
        req_valid_i = 4'hF;
        #1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (n < 8 && fu_valid_o) begin
                gid = 0;
                for (int k = N - 1; k >= 0; k--) if (req_ready_o[k]) gid = k;
                check($sformatf("fair_grant%0d", n), gid, n % N);
                n++;
            end
            tick();
            if (n >= 8) break;
        end
        req_valid_i = '0;
        check("fair_count", n, 8);
        drain();

        // Backpressure: credits run out, one pop admits exactly one more grant
        rsp_ready_i = '0;
        req_valid_i = 4'hF;
        #1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (fu_valid_o) n++;
            tick();
        end
        check("bp_grants", n, D);
        check("bp_ready_zero", req_ready_o, 0);
        check("bp_credit_zero", dut.credit_cnt_q, 0);
        rsp_ready_i = 4'hF;
        #1;
        check("bp_pop_cycle_ready", req_ready_o, 0);
        check("bp_head_valid", rsp_valid_o, 4'b0001);
        tick();
        rsp_ready_i = '0;
        #1;
        check("bp_next_ready", req_ready_o, 4'b0001);
        check("bp_credit_one", dut.credit_cnt_q, 1);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (fu_valid_o) n++;
            tick();
        end
        check("bp_one_more", n, 1);
        req_valid_i = '0;
        rsp_ready_i = 4'hF;
        drain();

        // Reset with three operations in flight
        rsp_ready_i = '0;
        req_valid_i = 4'hF;
        #1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_req_ready", req_ready_o, 0);
        check("midrst_fu_valid", fu_valid_o, 0);
        check("midrst_rsp_valid", rsp_valid_o, 0);
        check("midrst_credit", dut.credit_cnt_q, D);
        tick();
        rst_n = 1'b1;
        req_valid_i = '0;
        tick();
        tick();
        tick();
        check("midrst_err", dut.err_q, 1);
        check("midrst_stale_dropped", rsp_valid_o, 0);
        check("midrst_credit_after", dut.credit_cnt_q, D);

        // Requester 2 issues three back-to-back operations; responses must keep issue order
        rsp_ready_i = 4'b0100;
        p0 = npop;
        for (int i = 0; i < 3; i++) begin
            set_req(2, 32'h4000_0000 + i, 32'h100 * (i + 1), 3'(i));
            req_valid_i = 4'b0100;
            #1;
            check($sformatf("order_ready%0d", i), req_ready_o, 4'b0100);
            tick();
        end
        req_valid_i = '0;
        for (int c = 0; c < 40 && npop - p0 < 3; c++) tick();
        check("order_beats", npop - p0, 3);
        check("order_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fadd_share_arb.md
FADD_SHARE_ARB -- requirements
Module: fadd_share_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one fadd pipeline.
REQ-002 SHALL have parameter EXPWIDTH, default 8, exponent width of operands.
REQ-003 SHALL have parameter PRECISION, default 24, significand width including hidden bit; operand width W = EXPWIDTH+PRECISION.
REQ-004 SHALL have parameter LATENCY, default 3, fixed cycles from fu_valid_o to fu_valid_i; legal range 1..8.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries; FIFO_DEPTH >= 2 SHALL be required.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid_i, input, NUM_REQ, per-requester operation valid.
REQ-009 SHALL have port req_ready_o, output, NUM_REQ, per-requester accept; one-hot or zero.
REQ-010 SHALL have port req_a_i / req_b_i, input, NUM_REQ*W each, packed operands, requester k at bits [k*W +: W].
REQ-011 SHALL have port req_rm_i, input, NUM_REQ*3, packed rounding modes.
REQ-012 SHALL have port fu_valid_o, output, 1, issue strobe to fadd pipeline.
REQ-013 SHALL have ports fu_a_o, fu_b_o (W) and fu_rm_o (3), outputs, issued operands and rounding mode.
REQ-014 SHALL have port fu_valid_i, input, 1, result strobe from pipeline; fu_result_i, input, W; fu_fflags_i, input, 5.
REQ-015 SHALL have port rsp_valid_o, output, NUM_REQ, one-hot result valid; rsp_ready_i, input, NUM_REQ.
REQ-016 SHALL have ports rsp_result_o (W) and rsp_fflags_o (5), outputs, shared response data bus.

Function
REQ-017 SHALL arbitrate round-robin: grant the lowest index k >= rr_ptr (wrapping) with req_valid_i[k]=1, only when credit_cnt > 0.
REQ-018 SHALL accept a request in the cycle req_valid_i[k] && req_ready_o[k]; fu_valid_o SHALL equal that handshake, with fu_a_o/fu_b_o/fu_rm_o driven combinationally from requester k.
REQ-019 SHALL set rr_ptr to (k+1) mod NUM_REQ after a grant to k; rr_ptr unchanged with no grant.
REQ-020 SHALL push the granted index into a LATENCY-deep tag shift register (valid+id) each cycle; the tag emerging at stage LATENCY identifies the requester of fu_result_i.
REQ-021 SHALL write {id, fu_result_i, fu_fflags_i} into the result FIFO when fu_valid_i=1; fu_valid_i without a valid emerging tag SHALL be ignored and set sticky err_q (internal, observable in simulation).
REQ-022 SHALL maintain credit_cnt = FIFO_DEPTH - (in-flight ops + FIFO occupancy): decrement on grant, increment on FIFO pop, unchanged on simultaneous grant and pop; never below 0 or above FIFO_DEPTH.
REQ-023 SHALL drive rsp_valid_o one-hot at the FIFO head id when non-empty, rsp_result_o/rsp_fflags_o from head; pop when rsp_ready_i[head id]=1.
REQ-024 SHALL keep responses per requester in issue order; no overtaking, as the pipeline is in-order.
REQ-025 SHALL allow FIFO push and pop in the same cycle when full (pop frees slot first) and when empty is not bypassed (result visible one cycle after fu_valid_i).
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; full/empty derived from a count register.
REQ-027 SHALL block the whole unit (all req_ready_o=0) when credit_cnt=0, including requesters whose own results are not pending (head-of-line blocking is accepted).

Reset
REQ-028 SHALL on rst_n=0 immediately clear: rr_ptr=0, credit_cnt=FIFO_DEPTH, tag valids=0, FIFO count/pointers=0, err_q=0; consequently req_ready_o=0, fu_valid_o=0, rsp_valid_o=0.
REQ-029 SHALL discard all in-flight operations on reset mid-operation; fu_valid_i returning after reset release without matching tag SHALL be dropped per REQ-021.

Verification
REQ-030 Single request: req_valid_i=4'b0010, a=0x3F800000, b=0x40000000, LATENCY=3 -> fu_valid_o cycle 0, result 0x40400000 in FIFO cycle 3, rsp_valid_o=4'b0010 cycle 4.
REQ-031 Fairness: req_valid_i=4'b1111 held 8 cycles, rsp_ready_i all 1 -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Backpressure: rsp_ready_i=0, all requesting -> exactly FIFO_DEPTH=4 grants, then req_ready_o=0; one rsp_ready_i pulse -> exactly one further grant.
REQ-033 Simultaneous grant and pop at credit_cnt=0 -> grant not issued that cycle (credit_cnt 0), issued next cycle; credit_cnt never exceeds 4.
REQ-034 Reset asserted with 3 ops in flight -> outputs zero same cycle; post-release credit_cnt=4, stale fu_valid_i dropped, err_q=1.
REQ-035 Ordering: requester 2 issues 3 ops back-to-back with others idle -> three rsp_valid_o=4'b0100 beats in issue order.
